// File: rtl/matrix_loader_if.sv
// Request/response bundle between the matrix-vector multiplier (master) and the
// matrix loader (slave): chunk request, base address, packed chunk and ready.
interface matrix_loader_if #(
    parameter int ADDR_W     = 12,
    parameter int DATA_WIDTH = 16,
    parameter int BANDWIDTH  = 16
);
    logic                            matrix_enable;
    logic [ADDR_W-1:0]               matrix_addr;
    logic [DATA_WIDTH*BANDWIDTH-1:0] matrix_data;
    logic                            matrix_ready;

    modport master (
        output matrix_enable,
        output matrix_addr,
        input  matrix_data,
        input  matrix_ready
    );

    modport slave (
        input  matrix_enable,
        input  matrix_addr,
        output matrix_data,
        output matrix_ready
    );
endinterface

// File: rtl/matrix_loader.sv
// Matrix chunk loader: gathers BANDWIDTH consecutive SRAM words into one packed chunk.
// Optional build macro MATRIX_LOADER_PERF_EN adds perf_loads/perf_busy counters.
//
// state | meaning
// IDLE  | waiting for matrix_enable; latches base address on accept
// FETCH | issuing one SRAM read (or zero-fill lane) per cycle
// DRAIN | all lanes issued, waiting for in-flight reads to land
// READY | chunk valid, held until matrix_enable drops
module matrix_loader #(
    parameter int  MAX_ROWS     = 64,
    parameter int  MAX_COLS     = 64,
    parameter int  BANDWIDTH    = 16,
    parameter int  DATA_WIDTH   = 16,
    parameter int  READ_LATENCY = 1,
    localparam int DEPTH        = MAX_ROWS * MAX_COLS,
    localparam int ADDR_W       = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    matrix_loader_if.slave        mif,
    output logic                  sram_en,
    output logic [ADDR_W-1:0]     sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_rdata
`ifdef MATRIX_LOADER_PERF_EN
    ,
    output logic [31:0]           perf_loads,
    output logic [31:0]           perf_busy
`endif
);
    localparam int               CNT_W     = $clog2(BANDWIDTH + 1);
    localparam int               LANE_W    = (BANDWIDTH > 1) ? $clog2(BANDWIDTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] BW_CNT    = CNT_W'(BANDWIDTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, READY} state_t;

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         base_q, base_d;
    logic [CNT_W-1:0]          issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]          recv_cnt_q, recv_cnt_d;
    logic                      ready_q, ready_d;
    logic                      sram_en_q, sram_en_d;
    logic [ADDR_W-1:0]         sram_addr_q, sram_addr_d;
    logic                      iss_vld_q, iss_vld_d;
    logic                      iss_zf_q, iss_zf_d;
    logic [READ_LATENCY-1:0]   tag_vld_q, tag_vld_d;
    logic [READ_LATENCY-1:0]   tag_zf_q, tag_zf_d;
    logic [DATA_WIDTH-1:0]     lane_q [BANDWIDTH];
    logic [DATA_WIDTH-1:0]     lane_d [BANDWIDTH];
`ifdef MATRIX_LOADER_PERF_EN
    logic [31:0]               perf_loads_q, perf_loads_d;
    logic [31:0]               perf_busy_q, perf_busy_d;
`endif

    logic                      issue_go;
    logic [ADDR_W-1:0]         issue_base;
    logic [CNT_W-1:0]          issue_idx;
    logic [ADDR_W:0]           issue_a;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        ready_d     = ready_q;
        sram_en_d   = 1'b0;
        sram_addr_d = sram_addr_q;
        iss_vld_d   = 1'b0;
        iss_zf_d    = 1'b0;
        lane_d      = lane_q;
        issue_go    = 1'b0;
        issue_base  = base_q;
        issue_idx   = issue_cnt_q;
        issue_a     = '0;

        // Tags travel alongside the SRAM pipeline so each returning word knows its fate.
        tag_vld_d[0] = iss_vld_q;
        tag_zf_d[0]  = iss_zf_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_zf_d[i]  = tag_zf_q[i-1];
        end

        if (tag_vld_q[READ_LATENCY-1] && (state_q == FETCH || state_q == DRAIN)) begin
            lane_d[recv_cnt_q[LANE_W-1:0]] = tag_zf_q[READ_LATENCY-1] ? '0 : sram_rdata;
            recv_cnt_d = recv_cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (mif.matrix_enable) begin
                    base_d      = mif.matrix_addr;
                    issue_base  = mif.matrix_addr;
                    issue_idx   = '0;
                    issue_go    = 1'b1;
                    issue_cnt_d = CNT_W'(1);
                    recv_cnt_d  = '0;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                if (issue_cnt_q < BW_CNT) begin
                    issue_go    = 1'b1;
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Completion is judged on the post-receive count so ready lands with the last word.
                if (recv_cnt_d == BW_CNT) begin
                    if (mif.matrix_enable) begin
                        ready_d = 1'b1;
                        state_d = READY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            READY: begin
                if (!mif.matrix_enable) begin
                    ready_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // One extra address bit lets a chunk run past DEPTH without wrapping to 0.
        if (issue_go) begin
            issue_a   = {1'b0, issue_base} + (ADDR_W + 1)'(issue_idx);
            iss_vld_d = 1'b1;
            if (issue_a < DEPTH_EXT) begin
                sram_en_d   = 1'b1;
                sram_addr_d = issue_a[ADDR_W-1:0];
            end else begin
                iss_zf_d = 1'b1;
            end
        end
    end

`ifdef MATRIX_LOADER_PERF_EN
    always_comb begin
        perf_loads_d = perf_loads_q;
        perf_busy_d  = perf_busy_q;
        if (state_q == DRAIN && state_d == READY) perf_loads_d = perf_loads_q + 32'd1;
        if (state_q == FETCH || state_q == DRAIN) perf_busy_d = perf_busy_q + 32'd1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            base_q       <= '0;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            ready_q      <= 1'b0;
            sram_en_q    <= 1'b0;
            sram_addr_q  <= '0;
            iss_vld_q    <= 1'b0;
            iss_zf_q     <= 1'b0;
            tag_vld_q    <= '0;
            tag_zf_q     <= '0;
            lane_q       <= '{default: '0};
`ifdef MATRIX_LOADER_PERF_EN
            perf_loads_q <= '0;
            perf_busy_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            issue_cnt_q  <= issue_cnt_d;
            recv_cnt_q   <= recv_cnt_d;
            ready_q      <= ready_d;
            sram_en_q    <= sram_en_d;
            sram_addr_q  <= sram_addr_d;
            iss_vld_q    <= iss_vld_d;
            iss_zf_q     <= iss_zf_d;
            tag_vld_q    <= tag_vld_d;
            tag_zf_q     <= tag_zf_d;
            lane_q       <= lane_d;
`ifdef MATRIX_LOADER_PERF_EN
            perf_loads_q <= perf_loads_d;
            perf_busy_q  <= perf_busy_d;
`endif
        end
    end

    always_comb begin
        mif.matrix_data = '0;
        for (int k = 0; k < BANDWIDTH; k++) begin
            mif.matrix_data[k*DATA_WIDTH +: DATA_WIDTH] = lane_q[k];
        end
    end

    assign mif.matrix_ready = ready_q;
    assign sram_en          = sram_en_q;
    assign sram_addr        = sram_addr_q;
`ifdef MATRIX_LOADER_PERF_EN
    assign perf_loads       = perf_loads_q;
    assign perf_busy        = perf_busy_q;
`endif

endmodule

// File: tb/tb_matrix_loader.sv
// Bench for matrix_loader: two instances (READ_LATENCY 1 and 3) share random requests
// and are compared against a chunk/latency reference model.
`timescale 1ns/1ps
module tb_matrix_loader;
    localparam int DEPTH = 4096;
    localparam int AW    = 12;
    localparam int BW    = 16;
    localparam int DW    = 16;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [AW-1:0] addr;
    int            cyc;

    logic [DW-1:0] mem [DEPTH];

    matrix_loader_if #(.ADDR_W(AW), .DATA_WIDTH(DW), .BANDWIDTH(BW)) mif0 ();
    matrix_loader_if #(.ADDR_W(AW), .DATA_WIDTH(DW), .BANDWIDTH(BW)) mif1 ();

    assign mif0.matrix_enable = en;
    assign mif0.matrix_addr   = addr;
    assign mif1.matrix_enable = en;
    assign mif1.matrix_addr   = addr;

    logic          sen0, sen1;
    logic [AW-1:0] sad0, sad1;
    logic [DW-1:0] srd0, srd1;
`ifdef MATRIX_LOADER_PERF_EN
    logic [31:0]   pl0, pl1, pb0, pb1;
`endif

    matrix_loader #(.READ_LATENCY(1)) u_l1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .mif        (mif0),
        .sram_en    (sen0),
        .sram_addr  (sad0),
        .sram_rdata (srd0)
`ifdef MATRIX_LOADER_PERF_EN
        ,
        .perf_loads (pl0),
        .perf_busy  (pb0)
`endif
    );

    matrix_loader #(.READ_LATENCY(3)) u_l3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .mif        (mif1),
        .sram_en    (sen1),
        .sram_addr  (sad1),
        .sram_rdata (srd1)
`ifdef MATRIX_LOADER_PERF_EN
        ,
        .perf_loads (pl1),
        .perf_busy  (pb1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM models: garbage on rdata whenever no read was issued.
    logic [DW-1:0] rp0 [4];
    logic [DW-1:0] rp1 [4];
    always @(posedge clk) begin
        rp0[0] <= sen0 ? mem[sad0] : DW'($urandom);
        rp1[0] <= sen1 ? mem[sad1] : DW'($urandom);
        for (int i = 1; i < 4; i++) begin
            rp0[i] <= rp0[i-1];
            rp1[i] <= rp1[i-1];
        end
    end
    assign srd0 = rp0[0];
    assign srd1 = rp1[2];

    logic             en_w  [2];
    logic [AW-1:0]    ad_w  [2];
    logic             rdy_w [2];
    logic [BW*DW-1:0] dat_w [2];
    assign en_w[0]  = sen0;
    assign en_w[1]  = sen1;
    assign ad_w[0]  = sad0;
    assign ad_w[1]  = sad1;
    assign rdy_w[0] = mif0.matrix_ready;
    assign rdy_w[1] = mif1.matrix_ready;
    assign dat_w[0] = mif0.matrix_data;
    assign dat_w[1] = mif1.matrix_data;

    int en_cnt [2], first_en [2], last_en [2], rdy_cyc [2], rdy_drop [2], addr_bad [2];
    int mon_base;
    int exp_loads [2], exp_busy [2];
    int n_chk  = 0;
    int n_pass = 0;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (en_w[i]) begin
                if (en_cnt[i] == 0) first_en[i] = cyc;
                last_en[i] = cyc;
                if (int'(ad_w[i]) != mon_base + en_cnt[i]) addr_bad[i]++;
                en_cnt[i]++;
            end
            if (rdy_w[i] && rdy_cyc[i] < 0) rdy_cyc[i] = cyc;
            if (!rdy_w[i] && rdy_cyc[i] >= 0) rdy_drop[i]++;
        end
    end

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [BW*DW-1:0] exp_chunk(input int base);
        logic [BW*DW-1:0] c = '0;
        for (int k = 0; k < BW; k++)
            if (base + k < DEPTH) c[k*DW +: DW] = mem[base + k];
        return c;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_chunk(input int i, input logic [BW*DW-1:0] exp, input string tag);
        for (int k = 0; k < BW; k++)
            check_eq($sformatf("%s L%0d lane%0d", tag, lat(i), k),
                     32'(dat_w[i][k*DW +: DW]), 32'(exp[k*DW +: DW]));
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon(input int base);
        mon_base = base;
        for (int i = 0; i < 2; i++) begin
            en_cnt[i]   = 0;
            first_en[i] = -1;
            last_en[i]  = -1;
            rdy_cyc[i]  = -1;
            rdy_drop[i] = 0;
            addr_bad[i] = 0;
        end
    endtask

    function automatic int n_reads(input int base);
        return (DEPTH - base < BW) ? DEPTH - base : BW;
    endfunction

    task automatic do_request(input int base, input int hold);
        int               t0;
        int               n;
        logic [BW*DW-1:0] exp;
        clear_mon(base);
        t0   = cyc;
        en   = 1'b1;
        addr = AW'(base);
        for (int w = 0; w < 60; w++) begin
            if (rdy_cyc[0] >= 0 && rdy_cyc[1] >= 0) break;
            step();
        end
        n   = n_reads(base);
        exp = exp_chunk(base);
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("ready_cycle b%0d L%0d", base, lat(i)), rdy_cyc[i], t0 + BW + lat(i) + 1);
            check_eq($sformatf("read_count b%0d L%0d", base, lat(i)), en_cnt[i], n);
            check_eq($sformatf("first_read b%0d L%0d", base, lat(i)), first_en[i], t0 + 1);
            check_eq($sformatf("last_read b%0d L%0d", base, lat(i)), last_en[i], t0 + n);
            check_eq($sformatf("read_addrs b%0d L%0d", base, lat(i)), addr_bad[i], 0);
        end
        repeat (hold) begin
            addr = AW'($urandom_range(0, DEPTH - 1));
            step();
        end
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("ready_held b%0d L%0d", base, lat(i)), 32'(rdy_w[i]), 1);
            check_eq($sformatf("ready_drop b%0d L%0d", base, lat(i)), rdy_drop[i], 0);
            check_eq($sformatf("no_refetch b%0d L%0d", base, lat(i)), en_cnt[i], n);
            check_chunk(i, exp, $sformatf("data b%0d", base));
        end
        en = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("ready_off b%0d L%0d", base, lat(i)), 32'(rdy_w[i]), 0);
            check_chunk(i, exp, $sformatf("held b%0d", base));
            exp_loads[i]++;
            exp_busy[i] += BW + lat(i);
        end
    endtask

    task automatic abandon(input int base);
        clear_mon(base);
        en   = 1'b1;
        addr = AW'(base);
        repeat (5) step();
        en = 1'b0;
        repeat (30) step();
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("abandon_ready b%0d L%0d", base, lat(i)), rdy_cyc[i], -1);
            check_eq($sformatf("abandon_reads b%0d L%0d", base, lat(i)), en_cnt[i], n_reads(base));
            check_eq($sformatf("abandon_addrs b%0d L%0d", base, lat(i)), addr_bad[i], 0);
            exp_busy[i] += BW + lat(i);
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("%s ready L%0d", tag, lat(i)), 32'(rdy_w[i]), 0);
            check_eq($sformatf("%s sram_en L%0d", tag, lat(i)), 32'(en_w[i]), 0);
            check_eq($sformatf("%s sram_addr L%0d", tag, lat(i)), 32'(ad_w[i]), 0);
            check_chunk(i, '0, tag);
            exp_loads[i] = 0;
            exp_busy[i]  = 0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 1'b0;
        en    = 1'b0;
        addr  = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        clear_mon(0);
        repeat (3) step();
        check_reset_state("reset");
        rst_n = 1'b1;
        step();

        do_request(0, 5);
        do_request(DEPTH - 4, 2);
        do_request(100, 1);
        abandon(200);
        do_request(16, 0);

        // Reset in the middle of a fetch.
        clear_mon(300);
        en   = 1'b1;
        addr = AW'(300);
        repeat (8) step();
        rst_n = 1'b0;
        #1;
        check_reset_state("midreset");
        en = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        do_request(48, 3);

        for (int r = 0; r < 24; r++) begin
            if ($urandom_range(0, 3) == 0) base = DEPTH - int'($urandom_range(1, 20));
            else base = int'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 5) == 0) abandon(base);
            else do_request(base, int'($urandom_range(0, 4)));
        end

`ifdef MATRIX_LOADER_PERF_EN
        check_eq("perf_loads L1", pl0, exp_loads[0]);
        check_eq("perf_busy L1", pb0, exp_busy[0]);
        check_eq("perf_loads L3", pl1, exp_loads[1]);
        check_eq("perf_busy L3", pb1, exp_busy[1]);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
